// File: rtl/btn_conditioner.sv
// Conditions raw active-low buttons: 2-flop sync, counter debounce,
// one-cycle press/release pulses and a press-toggled active-low LED per channel.
module btn_conditioner #(
    parameter int unsigned NUM_BTN         = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_n,
    output logic [NUM_BTN-1:0] pressed,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] led_n
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] q1;
    logic [NUM_BTN-1:0] q2;
    logic [CNT_W-1:0]   cnt   [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] pressed_d;
    logic [NUM_BTN-1:0] press_pulse_d;
    logic [NUM_BTN-1:0] release_pulse_d;
    logic [NUM_BTN-1:0] led_n_d;

    // State registers; sync flops reset to the released level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1            <= '1;
            q2            <= '1;
            pressed       <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            led_n         <= '1;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            q1            <= btn_n;
            q2            <= q1;
            pressed       <= pressed_d;
            press_pulse   <= press_pulse_d;
            release_pulse <= release_pulse_d;
            led_n         <= led_n_d;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= cnt_d[i];
            end
        end
    end

    // Debounce: q2 equal to pressed means the synced level disagrees with the
    // accepted state (q2 is active-low, pressed is active-high)
    always_comb begin
        pressed_d       = pressed;
        press_pulse_d   = '0;
        release_pulse_d = '0;
        led_n_d         = led_n;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = '0;
            if (q2[i] == pressed[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    pressed_d[i]       = ~pressed[i];
                    press_pulse_d[i]   = ~pressed[i];
                    release_pulse_d[i] = pressed[i];
                    if (!pressed[i]) begin
                        led_n_d[i] = ~led_n[i];
                    end
                end else begin
                    cnt_d[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule
